// File: rtl/cpu_ctrl_fsm.sv
// Control unit for the 16-bit RISC datapath: instruction register, field decode, sequencing FSM.
// Optional HALT state for opcode 111 is enabled by defining CTRL_HALT_EN.
module cpu_ctrl_fsm #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic              w,
    output logic [2:0]        rnum,
    output logic              write,
    output logic [1:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        aluop,
    output logic [DATA_W-1:0] sximm8
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StExec,
        StWriteRd,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic       is_mov_imm, is_mov_reg, is_mvn, is_alu, is_cmp, is_halt;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_alu     = (opcode == 3'b101) && (op != 2'b11);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

`ifdef CTRL_HALT_EN
    assign is_halt = (opcode == 3'b111);
`else
    assign is_halt = 1'b0;
`endif

    assign shift  = ir_q[4:3];
    // MOV reg runs through the ALU as an add with A forced to zero.
    assign aluop  = is_mov_reg ? 2'b00 : op;
    assign sximm8 = {{(DATA_W - 8){ir_q[7]}}, ir_q[7:0]};
    assign bsel   = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        w       = 1'b0;
        rnum    = 3'd0;
        write   = 1'b0;
        vsel    = 2'b00;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;

        unique case (state_q)
            StWait: begin
                w = 1'b1;
                if (load) ir_d = in;
                if (s) state_d = StDecode;
            end
            StDecode: begin
                if (is_mov_imm) begin
                    state_d = StWriteImm;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = StGetB;
                end else if (is_alu) begin
                    state_d = StGetA;
                end else if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StWait;
                end
            end
            StWriteImm: begin
                rnum    = rn;
                vsel    = 2'b10;
                write   = 1'b1;
                state_d = StWait;
            end
            StGetA: begin
                rnum    = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                rnum    = rm;
                loadb   = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                loadc   = 1'b1;
                asel    = is_mov_reg || is_mvn;
                loads   = (opcode == 3'b101);
                state_d = is_cmp ? StWait : StWriteRd;
            end
            StWriteRd: begin
                rnum    = rd;
                write   = 1'b1;
                state_d = StWait;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Control unit for the 16-bit RISC datapath: instruction register, field decoder and multi-cycle sequencing FSM.
- Sits between the cpu top-level pins (s, load, in, w) and the datapath strobes: regfile read/write, A/B/C registers, status register, operand muxes.
- Executes one instruction per s handshake and raises w when idle.

Parameters:
DATA_W, 16, datapath width; width of sximm8.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
s  input  1  start request, sampled only in WAIT
load  input  1  instruction register load enable
in  input  16  instruction word
w  output  1  idle/ready flag, high only in WAIT
rnum  output  3  regfile read/write index (Rn, Rd or Rm per state)
write  output  1  regfile write strobe
vsel  output  2  writeback select: 00 = C, 10 = sximm8; 01/11 reserved, never driven
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status register (N,V,Z)
asel  output  1  1 = A operand forced to zero
bsel  output  1  1 = B operand is sximm8 (always 0 in this ISA subset)
shift  output  2  shifter control, IR[4:3]
aluop  output  2  ALU op, IR[12:11]
sximm8  output  DATA_W  sign-extended IR[7:0]

Behaviour:
- Reset (reset=0, asynchronous): state = WAIT, IR = 0.
  - Outputs: w=1, all strobes 0, rnum=0, vsel=00, asel=0, bsel=0.
- IR loads from in on a rising edge when load=1 and state is WAIT; load is ignored in every other state.
- Decode is combinational from IR:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0]
- Moore outputs; strobes are 0 unless listed for the state.
- State actions:
  - WAIT: w=1. s=1 -> DECODE. If load and s are both 1 on the same edge, the new IR is captured and executed.
  - DECODE: no strobes. Next state:
    - MOV imm (110,10) -> WRITE_IMM
    - MOV reg (110,00) and MVN (101,11) -> GET_B
    - ADD (101,00), CMP (101,01), AND (101,10) -> GET_A
    - any other encoding -> WAIT, no register or status change
  - WRITE_IMM: rnum=Rn, vsel=10, write=1 -> WAIT.
  - GET_A: rnum=Rn, loada=1 -> GET_B.
  - GET_B: rnum=Rm, loadb=1 -> EXEC.
  - EXEC: loadc=1.
    - asel=1 for MOV reg and MVN; asel=0 otherwise.
    - loads=1 for all opcode-101 instructions; loads=0 for MOV reg.
    - aluop: MOV reg forces 00; otherwise IR[12:11].
    - CMP -> WAIT; all others -> WRITE_RD.
  - WRITE_RD: rnum=Rd, vsel=00, write=1 -> WAIT.
- Latency, with edge N being the one that samples s=1: w returns high after
  - edge N+2 for MOV imm
  - edge N+4 for MOV reg, MVN, CMP
  - edge N+5 for ADD, AND
  - edge N+1 for undefined encodings
- w falls in the cycle after edge N.
- s held high continuously: one instruction runs per WAIT visit; the FSM re-enters DECODE on the first WAIT cycle it samples s=1.
- Reset mid-instruction: aborts immediately to WAIT; any write strobe in flight is dropped.
- sximm8 = {(DATA_W-8) copies of IR[7], IR[7:0]}.

Optional Feature:
CTRL_HALT_EN
- Defined: opcode 111 (any op) goes DECODE -> HALT.
  - HALT holds w=0 and all strobes 0, ignores s and load, and is left only by reset.
- Undefined: opcode 111 is treated as an undefined encoding (DECODE -> WAIT, no side effects).

Test Plan:
- Reset, IR=0xD006 (MOV R0,#6), s pulse -> WRITE_IMM cycle: rnum=0, vsel=10, sximm8=0x0006, write=1; w high again after edge N+2.
- IR=0xD0F0 (MOV R0,#-16) -> sximm8=0xFFF0 during WRITE_IMM.
- IR=0xA148 (ADD R2,R1,R0,LSL#1) -> sequence:
  - GET_A: rnum=1, loada=1
  - GET_B: rnum=0, loadb=1
  - EXEC: loadc=1, loads=1, shift=01, aluop=00
  - WRITE_RD: rnum=2, write=1
  - 5 busy cycles total.
- IR=0xAF01 (CMP R7,R1) -> same path through EXEC (aluop=01, loads=1), then WAIT; write never asserted.
- IR=0xC060 (MOV R3,R0) -> GET_B rnum=0; EXEC asel=1, aluop=00, loads=0; WRITE_RD rnum=3. Load pulse with 0xD005 during GET_B -> IR unchanged.
- Reset during EXEC of ADD -> w=1 and strobes 0 immediately. With CTRL_HALT_EN, IR=0xE000 -> w stays 0 under further s pulses until reset; without the macro, w returns after 1 cycle.
